// File: rtl/lcd_w_shifter.sv
// rtl/lcd_w_shifter.sv - LCD digit staging: W' shift register with PLA decode, copied to W by TW/PTW.
module lcd_w_shifter #(
  parameter int W_LENGTH  = 9,
  parameter int SERIAL_TW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [2:0]              op,
  input  logic [3:0]              acc,
  input  logic                    lcd_cn,
  input  logic                    m_prime,
  output logic [4*W_LENGTH-1:0]   w_prime,
  output logic [4*W_LENGTH-1:0]   w_main,
  output logic                    busy,
  output logic                    tw_done
);

  localparam int IDX_W = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W_LENGTH - 1);

  localparam logic [2:0] OP_WR   = 3'd1;
  localparam logic [2:0] OP_WS   = 3'd2;
  localparam logic [2:0] OP_DTW  = 3'd3;
  localparam logic [2:0] OP_PDTW = 3'd4;
  localparam logic [2:0] OP_TW   = 3'd5;
  localparam logic [2:0] OP_PTW  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  // Segment decode PLA; entry k lives at bits [4k+3:4k], index is {lcd_cn, acc}.
  localparam logic [127:0] PLA_TABLE = {
    4'h0, 4'h4, 4'hE, 4'hD, 4'h0, 4'h4, 4'hF, 4'hF,
    4'hB, 4'hE, 4'hE, 4'hD, 4'hF, 4'h7, 4'h9, 4'hB,
    4'h2, 4'h2, 4'hA, 4'h2, 4'h0, 4'h0, 4'hA, 4'hE,
    4'h2, 4'hE, 4'hA, 4'h2, 4'h8, 4'hC, 4'h0, 4'hE
  };

  typedef enum logic {IDLE, COPY} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             tw_done_q;
  logic [3:0]       wp_q   [W_LENGTH];
  logic [3:0]       wp_d   [W_LENGTH];
  logic [3:0]       wm_q   [W_LENGTH];
  logic [3:0]       cbuf_q [W_LENGTH];

  logic       accept;
  logic [6:0] pla_bit;
  logic [3:0] digit;
  logic       shift_en;
  logic [3:0] shift_v;

  assign busy     = (state_q == COPY);
  assign op_ready = ~busy;
  assign tw_done  = tw_done_q;
  assign accept   = op_valid & op_ready;
  assign pla_bit  = {lcd_cn, acc, 2'b00};
  // The m' OR only applies to the low half of the PLA.
  assign digit    = PLA_TABLE[pla_bit +: 4] | {3'b000, ~lcd_cn & m_prime};

  always_comb begin
    wp_d     = wp_q;
    shift_en = 1'b0;
    shift_v  = 4'h0;
    if (accept) begin
      case (op)
        OP_WR:   begin shift_en = 1'b1; shift_v = acc & 4'h7; end
        OP_WS:   begin shift_en = 1'b1; shift_v = acc | 4'h8; end
        OP_DTW:  begin shift_en = 1'b1; shift_v = digit;      end
        OP_PDTW: begin
          wp_d[W_LENGTH-2] = wp_q[W_LENGTH-1];
          wp_d[W_LENGTH-1] = digit;
        end
        OP_CLR:  begin
          for (int i = 0; i < W_LENGTH; i++) wp_d[i] = 4'h0;
        end
        default: ;
      endcase
    end
    if (shift_en) begin
      for (int i = 0; i < W_LENGTH - 1; i++) wp_d[i] = wp_q[i+1];
      wp_d[W_LENGTH-1] = shift_v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tw_done_q <= 1'b0;
      for (int i = 0; i < W_LENGTH; i++) begin
        wp_q[i]   <= 4'h0;
        wm_q[i]   <= 4'h0;
        cbuf_q[i] <= 4'h0;
      end
    end else begin
      wp_q      <= wp_d;
      tw_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && op == OP_PTW) begin
            wm_q[W_LENGTH-2] <= wp_q[W_LENGTH-2];
            wm_q[W_LENGTH-1] <= wp_q[W_LENGTH-1];
          end
          if (accept && op == OP_TW) begin
            if (SERIAL_TW != 0) begin
              cbuf_q  <= wp_q;
              idx_q   <= '0;
              state_q <= COPY;
            end else begin
              wm_q      <= wp_q;
              tw_done_q <= 1'b1;
            end
          end
        end
        COPY: begin
          wm_q[idx_q] <= cbuf_q[idx_q];
          if (idx_q == IDX_LAST) begin
            idx_q     <= '0;
            state_q   <= IDLE;
            tw_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_prime = '0;
    w_main  = '0;
    for (int i = 0; i < W_LENGTH; i++) begin
      w_prime[4*i +: 4] = wp_q[i];
      w_main[4*i +: 4]  = wm_q[i];
    end
  end

endmodule

// File: tb/tb_lcd_w_shifter.sv
// tb/tb_lcd_w_shifter.sv - directed bench: serial 9-slot instance and parallel 2-slot instance.
module tb_lcd_w_shifter;

  logic        clk = 1'b0;
  logic        reset9, reset2;
  logic        op_valid9, op_valid2;
  logic [2:0]  op;
  logic [3:0]  acc;
  logic        lcd_cn, m_prime;

  logic        op_ready9, busy9, tw_done9;
  logic [35:0] w_prime9, w_main9;
  logic        op_ready2, busy2, tw_done2;
  logic [7:0]  w_prime2, w_main2;

  int n_cmp = 0;
  int n_err = 0;
  int busy2_seen = 0;

  always #5 clk = ~clk;

  lcd_w_shifter #(.W_LENGTH(9), .SERIAL_TW(1)) u9 (
    .clk(clk), .reset(reset9), .op_valid(op_valid9), .op_ready(op_ready9),
    .op(op), .acc(acc), .lcd_cn(lcd_cn), .m_prime(m_prime),
    .w_prime(w_prime9), .w_main(w_main9), .busy(busy9), .tw_done(tw_done9)
  );

  lcd_w_shifter #(.W_LENGTH(2), .SERIAL_TW(0)) u2 (
    .clk(clk), .reset(reset2), .op_valid(op_valid2), .op_ready(op_ready2),
    .op(op), .acc(acc), .lcd_cn(lcd_cn), .m_prime(m_prime),
    .w_prime(w_prime2), .w_main(w_main2), .busy(busy2), .tw_done(tw_done2)
  );

  always @(negedge clk) if (busy2 || !op_ready2) busy2_seen++;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op to the selected instance for a single edge, then sample 1ns later.
  task automatic step(input bit to9, input logic [2:0] o, input logic [3:0] a,
                      input logic cn, input logic mp);
    op = o; acc = a; lcd_cn = cn; m_prime = mp;
    op_valid9 = to9; op_valid2 = !to9;
    @(posedge clk); #1;
    op_valid9 = 1'b0; op_valid2 = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, done_busy;
    reset9 = 1'b1; reset2 = 1'b1;
    op_valid9 = 1'b0; op_valid2 = 1'b0;
    op = 3'd0; acc = 4'h0; lcd_cn = 1'b0; m_prime = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset9 = 1'b0; reset2 = 1'b0;

    chk("rst_wp9", w_prime9, 36'h0);
    chk("rst_wm9", w_main9, 36'h0);
    chk("rst_busy9", busy9, 0);
    chk("rst_done9", tw_done9, 0);
    chk("rst_ready9", op_ready9, 1);

    step(1, 3'd2, 4'h3, 0, 0);             // WS acc=3 -> B
    step(1, 3'd1, 4'hF, 0, 0);             // WR acc=F -> 7
    chk("ws_wr", w_prime9, 36'h7B0000000);

    step(1, 3'd3, 4'h1, 0, 1);             // DTW PLA[1]=0 | 1
    chk("dtw_or", w_prime9, 36'h17B000000);
    step(1, 3'd3, 4'h0, 1, 1);             // DTW PLA[16]=B, no OR
    chk("dtw_cn1", w_prime9, 36'hB17B00000);
    step(1, 3'd4, 4'h2, 0, 0);             // PDTW PLA[2]=C
    chk("pdtw", w_prime9, 36'hCB7B00000);

    step(1, 3'd0, 4'h5, 0, 0);
    chk("nop", w_prime9, 36'hCB7B00000);
    op = 3'd1; acc = 4'h5; op_valid9 = 1'b0;
    @(posedge clk); #1;
    chk("no_valid", w_prime9, 36'hCB7B00000);

    step(1, 3'd7, 4'h0, 0, 0);
    chk("clr_wp", w_prime9, 36'h0);
    chk("clr_wm", w_main9, 36'h0);

    for (int v = 1; v <= 7; v++) step(1, 3'd1, 4'(v), 0, 0);
    step(1, 3'd2, 4'h0, 0, 0);
    step(1, 3'd2, 4'h1, 0, 0);
    chk("load19", w_prime9, 36'h987654321);

    step(1, 3'd6, 4'h0, 0, 0);
    chk("ptw9", w_main9, 36'h980000000);

    step(1, 3'd5, 4'h0, 0, 0);
    chk("tw_busy", busy9, 1);
    chk("tw_ready", op_ready9, 0);
    busy_cnt = 0; done_cnt = 0; done_at = -1; done_busy = -1;
    for (int i = 0; i < 14; i++) begin
      busy_cnt += int'(busy9);
      if (tw_done9) begin
        done_cnt++; done_at = i; done_busy = int'(busy9);
      end
      if (i == 0) begin op = 3'd1; acc = 4'h5; op_valid9 = 1'b1; end
      if (i == 3) op_valid9 = 1'b0;
      @(posedge clk); #1;
    end
    chk("tw_busy_cycles", 36'(busy_cnt), 36'd9);
    chk("tw_done_count", 36'(done_cnt), 36'd1);
    chk("tw_done_at", 36'(done_at), 36'd9);
    chk("tw_done_busy", 36'(done_busy), 36'd0);
    chk("tw_wm", w_main9, 36'h987654321);
    chk("tw_wp_frozen", w_prime9, 36'h987654321);

    step(1, 3'd5, 4'h0, 0, 0);             // 1st COPY cycle
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy", busy9, 1);              // 4th COPY cycle
    reset9 = 1'b1;
    @(posedge clk); #1;
    reset9 = 1'b0;
    chk("mrst_wp", w_prime9, 36'h0);
    chk("mrst_wm", w_main9, 36'h0);
    chk("mrst_busy", busy9, 0);
    chk("mrst_ready", op_ready9, 1);
    done_cnt = int'(tw_done9);
    repeat (10) begin @(posedge clk); #1; done_cnt += int'(tw_done9); end
    chk("mrst_no_done", 36'(done_cnt), 36'd0);

    step(0, 3'd1, 4'h3, 0, 0);
    step(0, 3'd2, 4'h4, 0, 0);
    chk("w2_load", 36'(w_prime2), 36'hC3);
    step(0, 3'd6, 4'h0, 0, 0);
    chk("w2_ptw", 36'(w_main2), 36'hC3);
    chk("w2_ptw_nodone", tw_done2, 0);
    step(0, 3'd7, 4'h0, 0, 0);
    step(0, 3'd1, 4'h5, 0, 0);
    step(0, 3'd1, 4'h6, 0, 0);
    chk("w2_load2", 36'(w_prime2), 36'h65);
    chk("w2_wm_hold", 36'(w_main2), 36'hC3);
    step(0, 3'd5, 4'h0, 0, 0);
    chk("w2_tw", 36'(w_main2), 36'h65);
    chk("w2_done", tw_done2, 1);
    chk("w2_busy", busy2, 0);
    @(posedge clk); #1;
    chk("w2_done_pulse", tw_done2, 0);
    chk("w2_never_busy", 36'(busy2_seen), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_w_shifter.md
LCD_W_SHIFTER -- requirements
Module: lcd_w_shifter

Interface
REQ-001 SHALL provide parameter W_LENGTH, default 9, number of 4-bit digit slots in W' and W (legal 2..9).
REQ-002 SHALL provide parameter SERIAL_TW, default 1; 1 = TW copies one nibble per cycle, 0 = TW copies in one cycle.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  op presented this cycle.
REQ-006 SHALL have port op_ready  output  1  block can accept an op.
REQ-007 SHALL have port op  input  3  0 NOP, 1 WR, 2 WS, 3 DTW, 4 PDTW, 5 TW, 6 PTW, 7 CLR.
REQ-008 SHALL have port acc  input  4  CPU accumulator value.
REQ-009 SHALL have port lcd_cn  input  1  CN flag, PLA high index bit.
REQ-010 SHALL have port m_prime  input  1  m' flag.
REQ-011 SHALL have port w_prime  output  4*W_LENGTH  W' slots; slot i at bits [4i+3:4i].
REQ-012 SHALL have port w_main  output  4*W_LENGTH  W slots, same packing.
REQ-013 SHALL have port busy  output  1  serial TW copy in progress.
REQ-014 SHALL have port tw_done  output  1  one-cycle pulse when W fully updated by TW.

Function
REQ-015 SHALL accept an op only on a cycle with op_valid=1 and op_ready=1; ops with op_ready=0 are dropped, never queued.
REQ-016 SHALL drive op_ready = ~busy.
REQ-017 SHALL implement "shift in v": slot i <= slot i+1 for i in 0..W_LENGTH-2; slot W_LENGTH-1 <= v; one cycle.
REQ-018 WR SHALL shift in (acc & 4'h7); WS SHALL shift in (acc | 4'h8).
REQ-019 DTW SHALL shift in digit = PLA[{lcd_cn, acc}] with bit0 ORed with (~lcd_cn & m_prime).
REQ-020 The PLA table, index 0..31, SHALL be hex E,0,C,8,2,A,E,2,E,A,0,0,2,A,2,2,B,9,7,F,D,E,E,B,F,F,4,0,D,E,4,0.
REQ-021 PDTW SHALL set slot W_LENGTH-2 <= slot W_LENGTH-1 and slot W_LENGTH-1 <= digit (REQ-019); other slots unchanged.
REQ-022 PTW SHALL copy W' slots W_LENGTH-2 and W_LENGTH-1 into W in one cycle; other W slots unchanged.
REQ-023 CLR SHALL zero all W' slots in one cycle; W unchanged.
REQ-024 With SERIAL_TW=0, TW SHALL copy all W' slots to W on the accept edge and pulse tw_done the following cycle; busy stays 0.
REQ-025 With SERIAL_TW=1, the FSM SHALL have states IDLE and COPY with index counter idx (width clog2(W_LENGTH)).
REQ-026 IDLE: on accepted TW, SHALL snapshot W' into a copy buffer, set idx=0, go to COPY.
REQ-027 COPY: each cycle SHALL write W[idx] <= buffer[idx], increment idx; after writing idx=W_LENGTH-1 SHALL return to IDLE and pulse tw_done in that same cycle.
REQ-028 busy SHALL be 1 exactly for the W_LENGTH cycles spent in COPY; TW accepted at edge N gives W complete and tw_done=1 in the cycle after edge N+W_LENGTH.
REQ-029 W' SHALL remain frozen during COPY (no op accepted); W is written only by TW and PTW.
REQ-030 idx SHALL never exceed W_LENGTH-1; no wrap beyond the top slot.
REQ-031 NOP and op_valid=0 SHALL leave all state unchanged.

Reset
REQ-032 reset SHALL zero all W' and W slots, the copy buffer and idx, force state IDLE, and drive busy=0, tw_done=0, op_ready=1 on the following cycle.
REQ-033 reset SHALL take priority over any op, including mid-COPY; a partial copy is discarded, with no tw_done pulse.

Verification
REQ-034 W_LENGTH=9, reset, WS acc=3, WR acc=F -> slot 8=7, slot 7=B, slots 0..6=0.
REQ-035 DTW cn=0 m'=1 acc=1 -> slot 8=1; DTW cn=1 m'=1 acc=0 -> slot 8=B (no OR); PDTW cn=0 m'=0 acc=2 -> slot 7=previous slot 8, slot 8=C.
REQ-036 SERIAL_TW=1, W' loaded 1..9, TW -> busy high 9 cycles, op_ready low, WR during busy dropped, W slot i = i+1, single tw_done pulse.
REQ-037 Reset asserted in 4th COPY cycle -> next cycle all W/W' = 0, busy=0, no tw_done.
REQ-038 W_LENGTH=2, SERIAL_TW=0: PTW and TW both copy both slots; tw_done one cycle after TW, busy never 1.
